// File: rtl/branch_history_table_pkg.sv
// Shared constants for the branch direction predictor: 2-bit counter states
// and the position of the table index inside a PC.
package branch_history_table_pkg;

   // 2-bit saturating counter states
   localparam logic [1:0] BHT_SN = 2'b00;   // strongly not-taken
   localparam logic [1:0] BHT_WN = 2'b01;   // weakly not-taken
   localparam logic [1:0] BHT_WT = 2'b10;   // weakly taken
   localparam logic [1:0] BHT_ST = 2'b11;   // strongly taken

   // Instructions are word aligned, so the index starts above the byte offset
   localparam int BHT_IDX_LSB = 2;

endpackage

// File: rtl/branch_history_table_sat_cnt2.sv
// Combinational step of a 2-bit saturating direction counter.
// Taken moves one state toward strongly-taken, not-taken one state toward
// strongly-not-taken; both ends hold instead of wrapping.
module sat_cnt2
   import branch_history_table_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   // Next counter state from the current state and the resolved outcome
   always_comb begin
      nxt = cur;
      case (cur)
         BHT_SN:  nxt = taken ? BHT_WN : BHT_SN;
         BHT_WN:  nxt = taken ? BHT_WT : BHT_SN;
         BHT_WT:  nxt = taken ? BHT_ST : BHT_WN;
         BHT_ST:  nxt = taken ? BHT_ST : BHT_WT;
         default: nxt = BHT_WN;
      endcase
   end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: untagged array of 2-bit saturating counters indexed
// by word PC. IF reads a prediction combinationally; EX writes back the
// resolved outcome and bumps the branch/mispredict statistics.
module branch_history_table
   import branch_history_table_pkg::*;
#(
   parameter int         IDX_W    = 7,
   parameter logic [1:0] CNT_INIT = 2'b01,
   parameter int         STAT_W   = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       PCF,
   output logic              isBhtTaken,
   input  logic              BrValidE,
   input  logic              StallE,
   input  logic [31:0]       PCE,
   input  logic              BranchE,
   input  logic              isBhtTakenE,
   input  logic              bht_clear,
   output logic              MispredE,
   output logic [STAT_W-1:0] br_cnt,
   output logic [STAT_W-1:0] miss_cnt
);

   localparam int DEPTH = 2 ** IDX_W;

   // Flop array so the whole table can be reset/cleared in a single cycle
   logic [1:0]        ctrTable [DEPTH];
   logic [IDX_W-1:0]  rdIdx;
   logic [IDX_W-1:0]  wrIdx;
   logic              upd;
   logic [1:0]        curCtr;
   logic [1:0]        nxtCtr;
   logic [STAT_W-1:0] brCnt;
   logic [STAT_W-1:0] missCnt;
   logic              unusedPcBits;

   // Byte offset and the bits above the index never select an entry (aliasing is allowed)
   assign unusedPcBits = ^{PCF[31:IDX_W+BHT_IDX_LSB], PCF[BHT_IDX_LSB-1:0],
                           PCE[31:IDX_W+BHT_IDX_LSB], PCE[BHT_IDX_LSB-1:0]};

   assign rdIdx = PCF[BHT_IDX_LSB +: IDX_W];
   assign wrIdx = PCE[BHT_IDX_LSB +: IDX_W];

   // Prediction reads the stored value; a same-cycle write shows up next cycle
   assign isBhtTaken = ctrTable[rdIdx][1];

   // A branch retires only when it is real and EX is moving
   assign upd      = BrValidE & ~StallE;
   assign MispredE = upd & (isBhtTakenE ^ BranchE);
   assign curCtr   = ctrTable[wrIdx];

   sat_cnt2 uStep (
      .cur   (curCtr),
      .taken (BranchE),
      .nxt   (nxtCtr)
   );

   // Counter table and statistics: reset beats clear, clear drops any update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ctrTable[i] <= CNT_INIT;
         brCnt   <= '0;
         missCnt <= '0;
      end else if (bht_clear) begin
         for (int i = 0; i < DEPTH; i++) ctrTable[i] <= CNT_INIT;
         brCnt   <= '0;
         missCnt <= '0;
      end else if (upd) begin
         ctrTable[wrIdx] <= nxtCtr;
         brCnt           <= brCnt + {{(STAT_W-1){1'b0}}, 1'b1};
         if (MispredE) begin
            missCnt <= missCnt + {{(STAT_W-1){1'b0}}, 1'b1};
         end else begin
            missCnt <= missCnt;
         end
      end else begin
         brCnt   <= brCnt;
         missCnt <= missCnt;
      end
   end

   assign br_cnt   = brCnt;
   assign miss_cnt = missCnt;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios plus a
// randomized phase, all checked against an array-of-integers reference model.
module tb_branch_history_table;

   localparam int DEPTH = 128;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        isBhtTaken;
   logic        BrValidE;
   logic        StallE;
   logic [31:0] PCE;
   logic        BranchE;
   logic        isBhtTakenE;
   logic        bht_clear;
   logic        MispredE;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: counter value 0..3 per word index, plus statistics
   int          model [DEPTH];
   logic [31:0] brM;
   logic [31:0] missM;

   branch_history_table dut (
      .clk         (clk),
      .rst         (rst),
      .PCF         (PCF),
      .isBhtTaken  (isBhtTaken),
      .BrValidE    (BrValidE),
      .StallE      (StallE),
      .PCE         (PCE),
      .BranchE     (BranchE),
      .isBhtTakenE (isBhtTakenE),
      .bht_clear   (bht_clear),
      .MispredE    (MispredE),
      .br_cnt      (br_cnt),
      .miss_cnt    (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc / 32'd4) % 32'd128);
   endfunction

   function automatic logic modelPred(input logic [31:0] pc);
      return (model[idxOf(pc)] >= 2);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) model[i] = 1;
      brM   = 32'd0;
      missM = 32'd0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of traffic, entered and left at a falling edge
   task automatic cyc(input string tag, input logic [31:0] pcf, input logic v, input logic s,
                      input logic [31:0] pce, input logic br, input logic pe, input logic clr);
      logic mis;
      int   k;
      PCF = pcf; BrValidE = v; StallE = s; PCE = pce;
      BranchE = br; isBhtTakenE = pe; bht_clear = clr;
      #1;
      mis = v && !s && (pe != br);
      chk({tag, "/predPre"}, {31'd0, isBhtTaken}, {31'd0, modelPred(pcf)});
      chk({tag, "/mispred"}, {31'd0, MispredE}, {31'd0, mis});
      @(posedge clk);
      if (clr) begin
         modelReset();
      end else if (v && !s) begin
         k = idxOf(pce);
         if (br) model[k] = (model[k] == 3) ? 3 : model[k] + 1;
         else    model[k] = (model[k] == 0) ? 0 : model[k] - 1;
         brM = brM + 32'd1;
         if (mis) missM = missM + 32'd1;
      end
      @(negedge clk);
      chk({tag, "/predPost"}, {31'd0, isBhtTaken}, {31'd0, modelPred(pcf)});
      chk({tag, "/br_cnt"}, br_cnt, brM);
      chk({tag, "/miss_cnt"}, miss_cnt, missM);
   endtask

   task automatic idle();
      cyc("idle", 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rp;
      logic [31:0] rq;
      logic        rv, rs, rb, rpe, rc;

      rst = 1'b1; PCF = 32'd0; BrValidE = 1'b0; StallE = 1'b0; PCE = 32'd0;
      BranchE = 1'b0; isBhtTakenE = 1'b0; bht_clear = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: reset state everywhere
      for (int i = 0; i < DEPTH; i++) begin
         PCF = i * 4;
         #1;
         chk("reset/sweep", {31'd0, isBhtTaken}, 32'd0);
      end
      chk("reset/br_cnt", br_cnt, 32'd0);
      chk("reset/miss_cnt", miss_cnt, 32'd0);
      @(negedge clk);

      // 2: saturation at 0x100, 4x taken then 1x not-taken
      for (int i = 0; i < 4; i++)
         cyc("sat/T", 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, modelPred(32'h100), 1'b0);
      chk("sat/ctr11", model[idxOf(32'h100)], 3);
      cyc("sat/N", 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, modelPred(32'h100), 1'b0);
      chk("sat/after_N", {31'd0, isBhtTaken}, 32'd1);

      // 3: aliasing
      cyc("alias/T", 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);
      cyc("alias/rd210", 32'h210, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("alias/0x210", {31'd0, isBhtTaken}, 32'd1);
      PCF = 32'h14;
      #1;
      chk("alias/0x14", {31'd0, isBhtTaken}, 32'd0);
      @(negedge clk);

      // 4: same-cycle read/write of one index
      PCF = 32'h40; PCE = 32'h40; BrValidE = 1'b1; StallE = 1'b0;
      BranchE = 1'b1; isBhtTakenE = 1'b0; bht_clear = 1'b0;
      #1;
      chk("rw/same_cycle", {31'd0, isBhtTaken}, 32'd0);
      @(posedge clk);
      model[idxOf(32'h40)] = 2; brM = brM + 32'd1; missM = missM + 32'd1;
      @(negedge clk);
      BrValidE = 1'b0;
      #1;
      chk("rw/next_cycle", {31'd0, isBhtTaken}, 32'd1);
      @(negedge clk);

      // 5: qualifiers
      cyc("qual/clear", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         cyc("qual/stall", 32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
      cyc("qual/bubble", 32'h300, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);
      chk("qual/stall_br", br_cnt, 32'd0);
      cyc("qual/miss", 32'h300, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);
      chk("qual/br1", br_cnt, 32'd1);
      chk("qual/miss1", miss_cnt, 32'd1);
      cyc("qual/after", 32'h300, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);

      // 6: clear beats a concurrent update
      cyc("clr/T1", 32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
      cyc("clr/T2", 32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 1'b0);
      chk("clr/ctr11", model[idxOf(32'h80)], 3);
      cyc("clr/drop", 32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1);
      chk("clr/br0", br_cnt, 32'd0);
      chk("clr/pred", {31'd0, isBhtTaken}, 32'd0);

      // 6b: async reset between edges, with an update pending
      cyc("arst/T1", 32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
      cyc("arst/T2", 32'h80, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 1'b0);
      BrValidE = 1'b1; BranchE = 1'b1; PCF = 32'h80; PCE = 32'h80;
      #2;
      rst = 1'b1;
      #1;
      chk("arst/pred", {31'd0, isBhtTaken}, 32'd0);
      chk("arst/br", br_cnt, 32'd0);
      chk("arst/miss", miss_cnt, 32'd0);
      modelReset();
      BrValidE = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rp  = {22'd0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
         rq  = ($urandom_range(0, 1) == 0) ? rp : {22'd0, 10'($urandom)};
         rv  = ($urandom_range(0, 3) != 0);
         rs  = ($urandom_range(0, 4) == 0);
         rb  = 1'($urandom);
         rpe = ($urandom_range(0, 1) == 0) ? modelPred(rq) : 1'($urandom);
         rc  = ($urandom_range(0, 49) == 0);
         cyc("rand", rp, rv, rs, rq, rb, rpe, rc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
